// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_div_unit
//  Purpose  : Iterative 32-bit MIPS DIV/DIVU engine. It stalls the pipeline
//             while it computes, then writes the remainder to HI and the
//             quotient to LO in a single pulse.
//  Revision : 1.0  initial release
// ============================================================================
module hilo_div_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        annul,
    output logic        stall_req,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_last_iter = 5'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] dvs_abs_q, dvs_abs_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] w_dvd_abs;
    logic [31:0] w_dvs_abs;
    logic [32:0] w_rem_shift;
    logic [32:0] w_rem_diff;
    logic        w_sub_ok;
    logic [31:0] w_rem_next;
    logic [31:0] w_quot_next;

    // Magnitudes of the incoming operands (only signed DIV takes abs values).
    always_comb begin
        w_dvd_abs = (signed_div && dividend[31]) ? (32'd0 - dividend) : dividend;
        w_dvs_abs = (signed_div && divisor[31])  ? (32'd0 - divisor)  : divisor;
    end

    // One restoring-division step on the {rem,quot} pair. The remainder stays
    // below the divisor, so 32 stored bits plus the shifted-in bit suffice.
    always_comb begin
        w_rem_shift = {rem_q, quot_q[31]};
        w_rem_diff  = w_rem_shift - {1'b0, dvs_abs_q};
        w_sub_ok    = (w_rem_shift >= {1'b0, dvs_abs_q});
        w_rem_next  = w_sub_ok ? w_rem_diff[31:0] : w_rem_shift[31:0];
        w_quot_next = {quot_q[30:0], w_sub_ok};
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvs_abs_d  = dvs_abs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        stall_req  = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !annul) begin
                    stall_req = 1'b1;
                    if (divisor == 32'd0) begin
                        // Divide by zero: fixed result, no iteration.
                        hi_d    = dividend;
                        lo_d    = 32'hFFFF_FFFF;
                        state_d = S_DONE;
                    end else begin
                        rem_d      = 32'd0;
                        quot_d     = w_dvd_abs;
                        dvs_abs_d  = w_dvs_abs;
                        neg_quot_d = signed_div & (dividend[31] ^ divisor[31]);
                        neg_rem_d  = signed_div & dividend[31];
                        cnt_d      = 5'd0;
                        state_d    = S_CALC;
                    end
                end
            end
            S_CALC: begin
                stall_req = 1'b1;
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d  = w_rem_next;
                    quot_d = w_quot_next;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == c_last_iter) begin
                        // Sign fix-up on the final step; negating 0x80000000
                        // wraps back to itself, which is the MIPS result.
                        lo_d    = neg_quot_q ? (32'd0 - w_quot_next) : w_quot_next;
                        hi_d    = neg_rem_q  ? (32'd0 - w_rem_next)  : w_rem_next;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                hi_we   = ~annul;
                lo_we   = ~annul;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            rem_q      <= 32'd0;
            quot_q     <= 32'd0;
            dvs_abs_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvs_abs_q  <= dvs_abs_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
`default_nettype wire
